uart_rx_ext: RTL and testbench

UART_RX_EXT -- requirements
Module: uart_rx_ext

---
 rtl/uart_rx_ext.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_ext.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ext.sv
// uart_rx_ext -- oversampling UART receiver with parity, stop-bit and break
// detection plus a saturating error counter.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (4..65535)
//   DATA_BITS     data bits per frame (5..8)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     stop bits checked per frame (1 or 2)
//
// Ports:
//   i_Clock       sole clock, all state on rising edge
//   i_Reset       asynchronous active-high reset
//   i_Rx_Serial   asynchronous serial line, idle high, LSB first
//   o_Rx_DV       one-cycle frame-complete strobe
//   o_Rx_Byte     received data, zero-extended above DATA_BITS
//   o_Parity_Err  parity mismatch on last frame
//   o_Frame_Err   stop bit sampled low on last frame
//   o_Break       all-zero frame including the terminating stop sample
//   o_Busy        high whenever the receiver is not idle
//   o_Err_Count   saturating count of frames with any error
module uart_rx_ext #(
  parameter int CLKS_PER_BIT = 64,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Parity_Err,
  output logic       o_Frame_Err,
  output logic       o_Break,
  output logic       o_Busy,
  output logic [7:0] o_Err_Count
);

  // Elaboration-time parameter checks.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_rx_ext: CLKS_PER_BIT must be in 4..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data
    $error("uart_rx_ext: DATA_BITS must be in 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_ext: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_rx_ext: STOP_BITS must be 1 or 2");
  end

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_CNT   = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } state_t;

  state_t                 state_reg;
  logic                   sync_reg;
  logic                   line_reg;      // synchronized serial line
  logic [CNT_W-1:0]       cnt_reg;
  logic [2:0]             bit_idx_reg;
  logic                   stop_idx_reg;
  logic [DATA_BITS-1:0]   shift_reg;     // data shifts in from the top, LSB first
  logic                   par_bit_reg;
  logic                   dv_reg;
  logic [DATA_BITS-1:0]   byte_reg;
  logic                   perr_reg;
  logic                   ferr_reg;
  logic                   brk_reg;
  logic [7:0]             err_cnt_reg;

  logic                   par_calc;
  logic                   brk_calc;

  // Parity verdict from the assembled data and the sampled parity bit.
  always_comb begin
    par_calc = 1'b0;
    if (PARITY == 1) begin
      par_calc = (^shift_reg) ^ par_bit_reg;
    end else if (PARITY == 2) begin
      par_calc = ~((^shift_reg) ^ par_bit_reg);
    end
  end

  // Only meaningful when the terminating stop sample is low.
  assign brk_calc = (shift_reg == '0) && ((PARITY == 0) || !par_bit_reg);

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      sync_reg     <= 1'b1;
      line_reg     <= 1'b1;
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      bit_idx_reg  <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      par_bit_reg  <= 1'b0;
      dv_reg       <= 1'b0;
      byte_reg     <= '0;
      perr_reg     <= 1'b0;
      ferr_reg     <= 1'b0;
      brk_reg      <= 1'b0;
      err_cnt_reg  <= '0;
    end else begin
      sync_reg <= i_Rx_Serial;
      line_reg <= sync_reg;
      dv_reg   <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          cnt_reg      <= '0;
          bit_idx_reg  <= '0;
          stop_idx_reg <= 1'b0;
          if (!line_reg) begin
            state_reg <= ST_START;
          end
        end

        // Re-check the line at mid start bit; a high line here is a glitch.
        ST_START: begin
          if (cnt_reg == MID_CNT) begin
            cnt_reg   <= '0;
            state_reg <= line_reg ? ST_IDLE : ST_DATA;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (cnt_reg == BIT_END) begin
            cnt_reg   <= '0;
            shift_reg <= {line_reg, shift_reg[DATA_BITS-1:1]};
            if (bit_idx_reg == LAST_DATA) begin
              bit_idx_reg <= '0;
              state_reg   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        ST_PARITY: begin
          if (cnt_reg == BIT_END) begin
            cnt_reg     <= '0;
            par_bit_reg <= line_reg;
            state_reg   <= ST_STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        // A low stop sample ends the frame early with a frame error;
        // otherwise the frame ends after the last stop sample.
        ST_STOP: begin
          if (cnt_reg == BIT_END) begin
            cnt_reg <= '0;
            if (!line_reg || stop_idx_reg == LAST_STOP) begin
              dv_reg    <= 1'b1;
              byte_reg  <= shift_reg;
              perr_reg  <= par_calc;
              ferr_reg  <= !line_reg;
              brk_reg   <= !line_reg && brk_calc;
              if ((par_calc || !line_reg) && err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
              end
              state_reg <= line_reg ? ST_IDLE : ST_WAIT_HIGH;
            end else begin
              stop_idx_reg <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        // Hold off after a framing error until the line returns to idle,
        // so a long break yields a single frame.
        ST_WAIT_HIGH: begin
          cnt_reg <= '0;
          if (line_reg) begin
            state_reg <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Zero-extend the received data to 8 bits.
  for (genvar gi = 0; gi < 8; gi++) begin : g_byte
    if (gi < DATA_BITS) begin : g_used
      assign o_Rx_Byte[gi] = byte_reg[gi];
    end else begin : g_unused
      assign o_Rx_Byte[gi] = 1'b0;
    end
  end

  assign o_Rx_DV      = dv_reg;
  assign o_Parity_Err = perr_reg;
  assign o_Frame_Err  = ferr_reg;
  assign o_Break      = brk_reg;
  assign o_Busy       = (state_reg != ST_IDLE);
  assign o_Err_Count  = err_cnt_reg;

endmodule

// File: tb/tb_uart_rx_ext.sv
// Testbench for uart_rx_ext. Four receivers with different framing share the
// clock and reset; each has its own serial line. Received frames are collected
// on the falling clock edge and compared with a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx_ext;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] rx;
  logic [3:0] dv, perr, ferr, brk, busy;
  logic [7:0] rbyte [4];
  logic [7:0] ecnt  [4];

  int checks = 0;
  int errors = 0;
  int exp_cnt [4];

  typedef struct packed {
    logic [1:0] d;
    logic [7:0] b;
    logic       pe;
    logic       fe;
    logic       brk;
  } rec_t;

  rec_t dvq [$];

  always #5 clk = ~clk;

  // d0: 8N1, d1: 7E1, d2: 7O1, d3: 8N2
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .o_Rx_DV(dv[0]), .o_Rx_Byte(rbyte[0]),
    .o_Parity_Err(perr[0]), .o_Frame_Err(ferr[0]), .o_Break(brk[0]), .o_Busy(busy[0]),
    .o_Err_Count(ecnt[0]));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) u_7e1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .o_Rx_DV(dv[1]), .o_Rx_Byte(rbyte[1]),
    .o_Parity_Err(perr[1]), .o_Frame_Err(ferr[1]), .o_Break(brk[1]), .o_Busy(busy[1]),
    .o_Err_Count(ecnt[1]));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u_7o1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .o_Rx_DV(dv[2]), .o_Rx_Byte(rbyte[2]),
    .o_Parity_Err(perr[2]), .o_Frame_Err(ferr[2]), .o_Break(brk[2]), .o_Busy(busy[2]),
    .o_Err_Count(ecnt[2]));
  uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[3]), .o_Rx_DV(dv[3]), .o_Rx_Byte(rbyte[3]),
    .o_Parity_Err(perr[3]), .o_Frame_Err(ferr[3]), .o_Break(brk[3]), .o_Busy(busy[3]),
    .o_Err_Count(ecnt[3]));

  // Frame collector.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dv[i] === 1'b1) begin
        rec_t r;
        r.d   = 2'(i);
        r.b   = rbyte[i];
        r.pe  = perr[i];
        r.fe  = ferr[i];
        r.brk = brk[i];
        dvq.push_back(r);
      end
    end
  end

  function automatic int nb_of(int d);
    return (d == 1 || d == 2) ? 7 : 8;
  endfunction

  function automatic int pm_of(int d);
    return (d == 1 || d == 2) ? d : 0;
  endfunction

  function automatic int ns_of(int d);
    return (d == 3) ? 2 : 1;
  endfunction

  // Parity bit a correct transmitter would send.
  function automatic logic good_par(int d, logic [7:0] data);
    int ones;
    ones = $countones(data & 8'((1 << nb_of(d)) - 1));
    return (pm_of(d) == 1) ? logic'(ones % 2) : logic'(1 - ones % 2);
  endfunction

  // What the receiver must report for a frame with the given wire contents.
  function automatic rec_t model(int d, logic [7:0] data, logic pbit, logic [1:0] stops);
    rec_t r;
    int   ones;
    r.d  = 2'(d);
    r.b  = data & 8'((1 << nb_of(d)) - 1);
    ones = $countones(r.b) + ((pm_of(d) != 0) ? int'(pbit) : 0);
    r.pe = (pm_of(d) == 1 && ones % 2 == 1) || (pm_of(d) == 2 && ones % 2 == 0);
    r.fe = !stops[0] || (ns_of(d) == 2 && !stops[1]);
    r.brk = r.fe && (r.b == 8'h00) && (pm_of(d) == 0 || !pbit);
    return r;
  endfunction

  function automatic void bump(int d, rec_t r);
    if ((r.pe || r.fe) && exp_cnt[d] < 255) exp_cnt[d]++;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start, data, optional parity and stop bits; leaves the line at
  // the last stop value so callers can hold it low.
  task automatic send_frame(input int d, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops);
    rx[d] = 1'b0;
    tick(CPB);
    for (int i = 0; i < nb_of(d); i++) begin
      rx[d] = data[i];
      tick(CPB);
    end
    if (pm_of(d) != 0) begin
      rx[d] = pbit;
      tick(CPB);
    end
    for (int i = 0; i < ns_of(d); i++) begin
      rx[d] = stops[i];
      tick(CPB);
    end
  endtask

  task automatic idle_line(input int d, input int n);
    rx[d] = 1'b1;
    tick(n);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 4'hF;
    tick(3);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({dv[d], rbyte[d], perr[d], ferr[d], brk[d], busy[d], ecnt[d]} !== 21'h0) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h want 0", d,
                 {dv[d], rbyte[d], perr[d], ferr[d], brk[d], busy[d], ecnt[d]});
      end
    end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_basic;
    rec_t e;
    dvq.delete();
    send_frame(0, 8'hA5, 1'b0, 2'b11);
    idle_line(0, 20);
    e = model(0, 8'hA5, 1'b0, 2'b11);
    bump(0, e);
    checks++;
    if (dvq.size() !== 1) begin
      errors++;
      $display("FAIL basic_dv_count got %0d want 1", dvq.size());
    end else begin
      checks++;
      if (dvq[0] !== e) begin
        errors++;
        $display("FAIL basic_frame got %h want %h", dvq[0], e);
      end
    end
    checks++;
    if (ecnt[0] !== 8'(exp_cnt[0])) begin
      errors++;
      $display("FAIL basic_err_count got %0d want %0d", ecnt[0], exp_cnt[0]);
    end
  endtask

  task automatic test_back_to_back;
    dvq.delete();
    send_frame(0, 8'h00, 1'b0, 2'b11);
    send_frame(0, 8'hFF, 1'b0, 2'b11);
    idle_line(0, 20);
    checks++;
    if (dvq.size() !== 2) begin
      errors++;
      $display("FAIL b2b_dv_count got %0d want 2", dvq.size());
    end else begin
      checks++;
      if (dvq[0] !== model(0, 8'h00, 1'b0, 2'b11)) begin
        errors++;
        $display("FAIL b2b_first got %h want %h", dvq[0], model(0, 8'h00, 1'b0, 2'b11));
      end
      checks++;
      if (dvq[1] !== model(0, 8'hFF, 1'b0, 2'b11)) begin
        errors++;
        $display("FAIL b2b_second got %h want %h", dvq[1], model(0, 8'hFF, 1'b0, 2'b11));
      end
    end
  endtask

  task automatic test_glitch;
    int busy_cycles;
    dvq.delete();
    busy_cycles = 0;
    rx[0] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) rx[0] = 1'b1;
      tick(1);
      if (busy[0] === 1'b1) busy_cycles++;
    end
    checks++;
    if (dvq.size() !== 0) begin
      errors++;
      $display("FAIL glitch_no_dv got %0d want 0", dvq.size());
    end
    checks++;
    if (busy_cycles < 1 || busy_cycles > 11) begin
      errors++;
      $display("FAIL glitch_busy_cycles got %0d want 1..11", busy_cycles);
    end
    checks++;
    if (busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_idle got %b want 0", busy[0]);
    end
  endtask

  task automatic test_parity;
    rec_t e;
    logic pbit;
    // even parity, deliberately wrong parity bit
    dvq.delete();
    pbit = ~good_par(1, 8'h41);
    send_frame(1, 8'h41, pbit, 2'b11);
    idle_line(1, 20);
    e = model(1, 8'h41, pbit, 2'b11);
    bump(1, e);
    checks++;
    if (dvq.size() !== 1 || dvq[0] !== e) begin
      errors++;
      $display("FAIL parity_even_bad got n=%0d %h want %h", dvq.size(),
               (dvq.size() > 0) ? dvq[0] : rec_t'(0), e);
    end
    checks++;
    if (ecnt[1] !== 8'(exp_cnt[1])) begin
      errors++;
      $display("FAIL parity_even_count got %0d want %0d", ecnt[1], exp_cnt[1]);
    end
    // odd parity, correct parity bit
    dvq.delete();
    pbit = good_par(2, 8'h41);
    send_frame(2, 8'h41, pbit, 2'b11);
    idle_line(2, 20);
    e = model(2, 8'h41, pbit, 2'b11);
    bump(2, e);
    checks++;
    if (dvq.size() !== 1 || dvq[0] !== e) begin
      errors++;
      $display("FAIL parity_odd_good got n=%0d %h want %h", dvq.size(),
               (dvq.size() > 0) ? dvq[0] : rec_t'(0), e);
    end
    checks++;
    if (ecnt[2] !== 8'(exp_cnt[2])) begin
      errors++;
      $display("FAIL parity_odd_count got %0d want %0d", ecnt[2], exp_cnt[2]);
    end
  endtask

  task automatic test_stop2;
    rec_t e;
    dvq.delete();
    send_frame(3, 8'h5A, 1'b0, 2'b01);  // second stop bit low, line stays low
    tick(40);
    e = model(3, 8'h5A, 1'b0, 2'b01);
    bump(3, e);
    checks++;
    if (dvq.size() !== 1 || dvq[0] !== e) begin
      errors++;
      $display("FAIL stop2_frame got n=%0d %h want %h", dvq.size(),
               (dvq.size() > 0) ? dvq[0] : rec_t'(0), e);
    end
    checks++;
    if (busy[3] !== 1'b1) begin
      errors++;
      $display("FAIL stop2_wait_high got busy=%b want 1", busy[3]);
    end
    checks++;
    if (ecnt[3] !== 8'(exp_cnt[3])) begin
      errors++;
      $display("FAIL stop2_count got %0d want %0d", ecnt[3], exp_cnt[3]);
    end
    idle_line(3, 6);
    checks++;
    if (busy[3] !== 1'b0) begin
      errors++;
      $display("FAIL stop2_release got busy=%b want 0", busy[3]);
    end
  endtask

  task automatic test_break;
    rec_t e;
    dvq.delete();
    rx[0] = 1'b0;
    tick(20 * CPB);
    e = model(0, 8'h00, 1'b0, 2'b00);
    bump(0, e);
    checks++;
    if (dvq.size() !== 1 || dvq[0] !== e) begin
      errors++;
      $display("FAIL break_frame got n=%0d %h want %h", dvq.size(),
               (dvq.size() > 0) ? dvq[0] : rec_t'(0), e);
    end
    checks++;
    if (busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL break_hold got busy=%b want 1", busy[0]);
    end
    idle_line(0, 20);
    checks++;
    if (dvq.size() !== 1 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL break_release got n=%0d busy=%b want 1 0", dvq.size(), busy[0]);
    end
    send_frame(0, 8'h3C, 1'b0, 2'b11);
    idle_line(0, 20);
    e = model(0, 8'h3C, 1'b0, 2'b11);
    bump(0, e);
    checks++;
    if (dvq.size() !== 2 || dvq[1] !== e) begin
      errors++;
      $display("FAIL break_next_frame got n=%0d %h want %h", dvq.size(),
               (dvq.size() > 1) ? dvq[1] : rec_t'(0), e);
    end
    checks++;
    if (ecnt[0] !== 8'(exp_cnt[0])) begin
      errors++;
      $display("FAIL break_count got %0d want %0d", ecnt[0], exp_cnt[0]);
    end
  endtask

  task automatic test_random;
    rec_t       e;
    int         d;
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;
    for (int n = 0; n < 24; n++) begin
      d     = int'($urandom_range(0, 3));
      data  = 8'($urandom);
      pbit  = good_par(d, data) ^ ($urandom_range(0, 3) == 0);
      stops = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      dvq.delete();
      send_frame(d, data, pbit, stops);
      idle_line(d, 20);
      e = model(d, data, pbit, stops);
      bump(d, e);
      checks++;
      if (dvq.size() !== 1 || dvq[0] !== e) begin
        errors++;
        $display("FAIL random_frame dut%0d data=%h p=%b s=%b got n=%0d %h want %h", d, data,
                 pbit, stops, dvq.size(), (dvq.size() > 0) ? dvq[0] : rec_t'(0), e);
      end
      checks++;
      if (ecnt[d] !== 8'(exp_cnt[d])) begin
        errors++;
        $display("FAIL random_count dut%0d got %0d want %0d", d, ecnt[d], exp_cnt[d]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    rec_t e;
    dvq.delete();
    rx[0] = 1'b0;
    tick(CPB);
    rx[0] = 1'b1;
    tick(3 * CPB);          // now inside the data bits
    #3 rst = 1'b1;          // between clock edges
    #1;
    for (int d = 0; d < 4; d++) begin
      checks++;
      if ({dv[d], rbyte[d], perr[d], ferr[d], brk[d], busy[d], ecnt[d]} !== 21'h0) begin
        errors++;
        $display("FAIL async_reset dut%0d got %h want 0", d,
                 {dv[d], rbyte[d], perr[d], ferr[d], brk[d], busy[d], ecnt[d]});
      end
      exp_cnt[d] = 0;
    end
    rx    = 4'hE;           // line 0 low through reset release
    tick(3);
    rst = 1'b0;
    send_frame(0, 8'h96, 1'b0, 2'b11);
    idle_line(0, 20);
    e = model(0, 8'h96, 1'b0, 2'b11);
    bump(0, e);
    checks++;
    if (dvq.size() !== 1 || dvq[0] !== e) begin
      errors++;
      $display("FAIL post_reset_frame got n=%0d %h want %h", dvq.size(),
               (dvq.size() > 0) ? dvq[0] : rec_t'(0), e);
    end
  endtask

  task automatic test_err_saturation;
    rec_t       e;
    logic [7:0] data;
    dvq.delete();
    for (int n = 0; n < 256; n++) begin
      data = 8'($urandom);
      send_frame(0, data, 1'b0, 2'b00);
      idle_line(0, 6);
      e = model(0, data, 1'b0, 2'b00);
      bump(0, e);
      checks++;
      if (ecnt[0] !== 8'(exp_cnt[0])) begin
        errors++;
        $display("FAIL sat_count frame%0d got %0d want %0d", n, ecnt[0], exp_cnt[0]);
      end
    end
    checks++;
    if (ecnt[0] !== 8'd255 || dvq.size() !== 256) begin
      errors++;
      $display("FAIL sat_final got count=%0d dvs=%0d want 255 256", ecnt[0], dvq.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    rx  = 4'hF;
    for (int d = 0; d < 4; d++) exp_cnt[d] = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_parity();
    test_stop2();
    test_break();
    test_random();
    test_reset_mid_frame();
    test_err_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
